// File: rtl/imem_boot_loader.sv
// Arbitrates the single-port instruction RAM between CPU fetch and a UART program loader.
// A boot request holds the CPU, writes a length-prefixed big-endian word stream, then releases it.
module imem_boot_loader #(
    parameter int ROM_SIZE = 256,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              boot_req_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic [31:0]       cpu_pc_i,
    output logic [31:0]       cpu_inst_o,
    output logic              cpu_hold_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              boot_done_o,
    output logic              boot_err_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int          IDLE_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ROM_SIZE_L = ROM_SIZE;

    typedef enum logic [2:0] {RUN, HDR0, HDR1, LOAD, DONE, ERROR} state_e;

    state_e              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [23:0]         word_q, word_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                boot_done_q, boot_done_d;
    logic                boot_err_q, boot_err_d;

    logic [15:0]         hdr_count;
    logic                idle_hit;
    logic                pc_in_range;
    logic                unused_pc;

    assign hdr_count = {count_q[15:8], rx_data_i};
    assign idle_hit  = (idle_q == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        waddr_d     = waddr_q;
        words_d     = words_q;
        idle_d      = idle_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        boot_done_d = 1'b0;
        boot_err_d  = boot_err_q;

        // A boot request restarts from any state and wins over a byte arriving in the same cycle.
        if (boot_req_i) begin
            state_d    = HDR0;
            count_d    = '0;
            word_d     = '0;
            byte_cnt_d = '0;
            wr_ptr_d   = '0;
            words_d    = '0;
            idle_d     = '0;
            boot_err_d = 1'b0;
        end else begin
            case (state_q)
                HDR0: begin
                    if (rx_valid_i) begin
                        count_d[15:8] = rx_data_i;
                        idle_d        = '0;
                        state_d       = HDR1;
                    end
                end
                HDR1: begin
                    if (rx_valid_i) begin
                        count_d = hdr_count;
                        idle_d  = '0;
                        if (hdr_count == 16'd0) begin
                            state_d = DONE;
                        end else if (32'(hdr_count) > ROM_SIZE_L) begin
                            state_d    = ERROR;
                            boot_err_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else if (idle_hit) begin
                        state_d    = ERROR;
                        boot_err_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (rx_valid_i) begin
                        idle_d     = '0;
                        word_d     = {word_q[15:0], rx_data_i};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {word_q, rx_data_i};
                            waddr_d     = wr_ptr_q;
                            wr_ptr_d    = wr_ptr_q + 1'b1;
                            words_d     = words_q + 1'b1;
                            if (16'(words_q) + 16'd1 == count_q) begin
                                state_d = DONE;
                            end
                        end
                    end else if (idle_hit) begin
                        state_d    = ERROR;
                        boot_err_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d     = RUN;
                    boot_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            count_q     <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            waddr_q     <= '0;
            words_q     <= '0;
            idle_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            waddr_q     <= waddr_d;
            words_q     <= words_d;
            idle_q      <= idle_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
        end
    end

    // The write is registered, so the RAM sees the latched write pointer rather than the advanced one.
    // Bit 31 of the PC is dropped so kernel and user aliases fetch the same word.
    assign cpu_hold_o     = (state_q != RUN);
    assign pc_in_range    = ({3'b000, cpu_pc_i[30:2]} < ROM_SIZE_L);
    assign mem_addr_o     = cpu_hold_o ? waddr_q : cpu_pc_i[ADDR_W+1:2];
    assign cpu_inst_o     = (!cpu_hold_o && pc_in_range) ? mem_rdata_i : 32'h0;
    assign mem_we_o       = mem_we_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign boot_done_o    = boot_done_q;
    assign boot_err_o     = boot_err_q;
    assign words_loaded_o = words_q;
    assign unused_pc      = ^{cpu_pc_i[31], cpu_pc_i[1:0]};

endmodule
